// File: rtl/iob_modcnt_ctrl_pkg.sv
// Shared definitions for the modulo-counter control stage: state encoding
// and default widths.
package iob_modcnt_ctrl_pkg;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_PRESC_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/iob_modcnt_presc.sv
// Prescale counter: counts 0..presc_act while advancing, holds otherwise,
// clears on request; tc flags the terminal count.
module iob_modcnt_presc
  import iob_modcnt_ctrl_pkg::*;
#(
  parameter int PRESC_W = DEFAULT_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               advance,
  input  logic [PRESC_W-1:0] presc_act,
  output logic               tc
);

  logic [PRESC_W-1:0] presc_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (clear) begin
      presc_cnt <= '0;
    end else if (advance) begin
      presc_cnt <= tc ? '0 : presc_cnt + PRESC_W'(1);
    end
  end

  assign tc = (presc_cnt == presc_act);

endmodule

// File: rtl/iob_modcnt_ctrl.sv
// Control stage for iob_modcnt: start/pause/stop sequencing, prescaled
// enable, and configuration that only takes effect at a counter wrap.
module iob_modcnt_ctrl
  import iob_modcnt_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int PRESC_W = DEFAULT_PRESC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DATA_W-1:0]  cfg_mod,
  input  logic [DATA_W-1:0]  cfg_load,
  input  logic [PRESC_W-1:0] cfg_presc,
  input  logic               start,
  input  logic               pause,
  input  logic               stop,
  input  logic [DATA_W-1:0]  cnt_in,
  output logic               cnt_rst,
  output logic               cnt_en,
  output logic [DATA_W-1:0]  cnt_mod,
  output logic [DATA_W-1:0]  cnt_load_val,
  output logic               wrap,
  output logic               busy
);

  ctrl_state_t        state, state_nxt;
  logic [PRESC_W-1:0] presc_act;
  logic               pending;
  logic [DATA_W-1:0]  shadow_mod, shadow_load;
  logic [PRESC_W-1:0] shadow_presc;
  logic [DATA_W-1:0]  shadow_mod_nxt, shadow_load_nxt;
  logic [PRESC_W-1:0] shadow_presc_nxt;
  logic               cfg_xfer, enter_idle, presc_tc, wrap_d;

  iob_modcnt_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     ((state == IDLE) || (state == LOAD)),
    .advance   (state == RUN),
    .presc_act (presc_act),
    .tc        (presc_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = stop ? IDLE : RUN;
      RUN:     if (stop) state_nxt = IDLE;
               else if (pause) state_nxt = PAUSE;
      PAUSE:   if (stop) state_nxt = IDLE;
               else if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_rst    = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cnt_en     = (state == RUN) && presc_tc;
  assign cfg_ready  = !pending;
  assign cfg_xfer   = cfg_valid && cfg_ready;
  assign enter_idle = (state != IDLE) && (state_nxt == IDLE);
  assign wrap_d     = cnt_en && (cnt_in == cnt_mod - DATA_W'(1));

  // A word accepted on the stop cycle must still reach the active registers.
  assign shadow_mod_nxt   = cfg_xfer ? cfg_mod   : shadow_mod;
  assign shadow_load_nxt  = cfg_xfer ? cfg_load  : shadow_load;
  assign shadow_presc_nxt = cfg_xfer ? cfg_presc : shadow_presc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_mod      <= '0;
      cnt_load_val <= '0;
      presc_act    <= '0;
      pending      <= 1'b0;
      shadow_mod   <= '0;
      shadow_load  <= '0;
      shadow_presc <= '0;
      wrap         <= 1'b0;
    end else begin
      wrap <= wrap_d;
      if (cfg_xfer) begin
        shadow_mod   <= cfg_mod;
        shadow_load  <= cfg_load;
        shadow_presc <= cfg_presc;
      end
      if (state == IDLE) begin
        if (cfg_xfer) begin
          cnt_mod      <= cfg_mod;
          cnt_load_val <= cfg_load;
          presc_act    <= cfg_presc;
        end
      end else if (enter_idle) begin
        cnt_load_val <= shadow_load_nxt;
        if (pending || cfg_xfer) begin
          cnt_mod   <= shadow_mod_nxt;
          presc_act <= shadow_presc_nxt;
        end
        pending <= 1'b0;
      end else if (wrap_d && pending) begin
        cnt_mod   <= shadow_mod;
        presc_act <= shadow_presc;
        pending   <= 1'b0;
      end else if (cfg_xfer) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iob_modcnt_ctrl.sv
// Self-checking bench for iob_modcnt_ctrl with a behavioural model of the
// downstream modulo counter closing the cnt_in loop.
module tb_iob_modcnt_ctrl;

  localparam int DW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [DW-1:0] cfg_mod = '0;
  logic [DW-1:0] cfg_load = '0;
  logic [PW-1:0] cfg_presc = '0;
  logic          start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [DW-1:0] cnt_in;
  logic          cnt_rst, cnt_en, wrap, busy;
  logic [DW-1:0] cnt_mod, cnt_load_val;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iob_modcnt_ctrl #(.DATA_W(DW), .PRESC_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_mod      (cfg_mod),
    .cfg_load     (cfg_load),
    .cfg_presc    (cfg_presc),
    .start        (start),
    .pause        (pause),
    .stop         (stop),
    .cnt_in       (cnt_in),
    .cnt_rst      (cnt_rst),
    .cnt_en       (cnt_en),
    .cnt_mod      (cnt_mod),
    .cnt_load_val (cnt_load_val),
    .wrap         (wrap),
    .busy         (busy)
  );

  // Counter model: reset reads all-ones, first edge out of reset loads.
  logic [DW-1:0] cnt_q;
  logic          loaded;
  always_ff @(posedge clk) begin
    if (cnt_rst) begin
      cnt_q  <= '1;
      loaded <= 1'b0;
    end else if (!loaded) begin
      cnt_q  <= cnt_load_val;
      loaded <= 1'b1;
    end else if (cnt_en) begin
      cnt_q <= (cnt_q == cnt_mod - DW'(1)) ? '0 : cnt_q + DW'(1);
    end
  end
  assign cnt_in = cnt_q;

  typedef struct {
    logic          v;
    logic [DW-1:0] m;
    logic [DW-1:0] l;
    logic [PW-1:0] p;
    logic          st, pa, sp;
    logic [DW-1:0] e_cnt;
    logic          e_wrap, e_en, e_rst, e_busy, e_ready;
    logic [DW-1:0] e_mod;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic v, input logic [DW-1:0] m, input logic [DW-1:0] l,
                              input logic [PW-1:0] p, input logic st, input logic pa,
                              input logic sp, input logic [DW-1:0] ec, input logic ew,
                              input logic een, input logic er, input logic eb,
                              input logic erdy, input logic [DW-1:0] em);
    vec_t r;
    r.v = v; r.m = m; r.l = l; r.p = p; r.st = st; r.pa = pa; r.sp = sp;
    r.e_cnt = ec; r.e_wrap = ew; r.e_en = een; r.e_rst = er; r.e_busy = eb;
    r.e_ready = erdy; r.e_mod = em;
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [DW-1:0] m, input logic [DW-1:0] l,
                               input logic [PW-1:0] p, input logic st, input logic pa,
                               input logic sp);
    @(negedge clk);
    cfg_valid = v; cfg_mod = m; cfg_load = l; cfg_presc = p;
    start = st; pause = pa; stop = sp;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic step();
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Reset and its output values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cnt_rst", cnt_rst, 1);
    checkOutput("rst_cnt_en", cnt_en, 0);
    checkOutput("rst_cnt_mod", cnt_mod, 0);
    checkOutput("rst_load_val", cnt_load_val, 0);
    checkOutput("rst_wrap", wrap, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic run (mod=4, load=2), deferred mod=2, then stop.
    //                 v  mod   ld   pr  st pa sp   cnt   wr en rs bz rdy mod
    vecs[0]  = mk(1, 8'd4, 8'd2, 4'd0, 0, 0, 0, 8'hFF, 0, 0, 1, 0, 1, 8'd4);
    vecs[1]  = mk(0, 8'd0, 8'd0, 4'd0, 1, 0, 0, 8'hFF, 0, 0, 0, 1, 1, 8'd4);
    vecs[2]  = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd2,  0, 1, 0, 1, 1, 8'd4);
    vecs[3]  = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd3,  0, 1, 0, 1, 1, 8'd4);
    vecs[4]  = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd0,  1, 1, 0, 1, 1, 8'd4);
    vecs[5]  = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd1,  0, 1, 0, 1, 1, 8'd4);
    vecs[6]  = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd2,  0, 1, 0, 1, 1, 8'd4);
    vecs[7]  = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd3,  0, 1, 0, 1, 1, 8'd4);
    vecs[8]  = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd0,  1, 1, 0, 1, 1, 8'd4);
    vecs[9]  = mk(1, 8'd2, 8'd0, 4'd0, 0, 0, 0, 8'd1,  0, 1, 0, 1, 0, 8'd4);
    vecs[10] = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd2,  0, 1, 0, 1, 0, 8'd4);
    vecs[11] = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd3,  0, 1, 0, 1, 0, 8'd4);
    vecs[12] = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd0,  1, 1, 0, 1, 1, 8'd2);
    vecs[13] = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd1,  0, 1, 0, 1, 1, 8'd2);
    vecs[14] = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'd0,  1, 1, 0, 1, 1, 8'd2);
    vecs[15] = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 1, 8'd1,  0, 0, 1, 0, 1, 8'd2);
    vecs[16] = mk(0, 8'd0, 8'd0, 4'd0, 0, 0, 0, 8'hFF, 0, 0, 1, 0, 1, 8'd2);

    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].v, vecs[i].m, vecs[i].l, vecs[i].p,
                    vecs[i].st, vecs[i].pa, vecs[i].sp);
      checkOutput($sformatf("vec%0d_cnt", i), cnt_in, vecs[i].e_cnt);
      checkOutput($sformatf("vec%0d_wrap", i), wrap, vecs[i].e_wrap);
      checkOutput($sformatf("vec%0d_en", i), cnt_en, vecs[i].e_en);
      checkOutput($sformatf("vec%0d_rst", i), cnt_rst, vecs[i].e_rst);
      checkOutput($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      checkOutput($sformatf("vec%0d_ready", i), cfg_ready, vecs[i].e_ready);
      checkOutput($sformatf("vec%0d_mod", i), cnt_mod, vecs[i].e_mod);
    end

    // Prescale by 3 with mod=3: enable every third cycle, wrap every nine.
    applyStimulus(1'b1, 8'd3, 8'd0, 4'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 18; i++) begin
      checkOutput($sformatf("presc%0d_en", i), cnt_en, (i % 3) == 2);
      checkOutput($sformatf("presc%0d_cnt", i), cnt_in, (i / 3) % 3);
      checkOutput($sformatf("presc%0d_wrap", i), wrap, (i > 0) && ((i % 9) == 0));
      step();
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Pause mid-count with presc=1, hold, resume in phase.
    applyStimulus(1'b1, 8'd4, 8'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    step();
    checkOutput("pause_pre_cnt", cnt_in, 1);
    checkOutput("pause_pre_en", cnt_en, 0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("pause%0d_en", i), cnt_en, 0);
      checkOutput($sformatf("pause%0d_cnt", i), cnt_in, 1);
      checkOutput($sformatf("pause%0d_busy", i), busy, 1);
      step();
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("resume_en", cnt_en, 1);
    checkOutput("resume_cnt", cnt_in, 1);
    step();
    checkOutput("resume_next_en", cnt_en, 0);
    checkOutput("resume_next_cnt", cnt_in, 2);

    // Stop while a config is pending: committed on IDLE entry.
    applyStimulus(1'b1, 8'd7, 8'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("pend_ready", cfg_ready, 0);
    checkOutput("pend_mod_old", cnt_mod, 4);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("stop_rst", cnt_rst, 1);
    checkOutput("stop_mod", cnt_mod, 7);
    checkOutput("stop_load", cnt_load_val, 5);
    checkOutput("stop_ready", cfg_ready, 1);
    step();
    checkOutput("stop_cnt_ones", cnt_in, 8'hFF);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("restart_cnt0", cnt_in, 5);
    step();
    checkOutput("restart_cnt1", cnt_in, 6);
    checkOutput("restart_wrap1", wrap, 0);
    step();
    checkOutput("restart_cnt2", cnt_in, 0);
    checkOutput("restart_wrap2", wrap, 1);

    // Reset in RUN with start/pause also high and a config pending.
    applyStimulus(1'b1, 8'd3, 8'd1, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("prerst_ready", cfg_ready, 0);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; pause = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_rst", cnt_rst, 1);
    checkOutput("midrst_en", cnt_en, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_wrap", wrap, 0);
    checkOutput("midrst_mod", cnt_mod, 0);
    checkOutput("midrst_load", cnt_load_val, 0);
    checkOutput("midrst_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; pause = 1'b0;
    step();
    checkOutput("postrst_busy", busy, 0);

    // mod=1: wraps on every enable, count stays 0.
    applyStimulus(1'b1, 8'd1, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("mod1_cnt0", cnt_in, 0);
    checkOutput("mod1_wrap0", wrap, 0);
    for (int i = 1; i < 4; i++) begin
      step();
      checkOutput($sformatf("mod1_cnt%0d", i), cnt_in, 0);
      checkOutput($sformatf("mod1_wrap%0d", i), wrap, 1);
    end
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Load above modulus: rolls over through all-ones before the first wrap.
    applyStimulus(1'b1, 8'd3, 8'd250, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      logic [DW-1:0] exp_c;
      exp_c = (i < 6) ? DW'(250 + i) : DW'((i - 6) % 3);
      checkOutput($sformatf("big%0d_cnt", i), cnt_in, exp_c);
      checkOutput($sformatf("big%0d_wrap", i), wrap, i == 9);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
